reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-side scheduler for the 32-entry register file: tracks in-flight writes per destination register and gates instruction issue on RAW and write-count hazards.
- Sits between decode and the register-file read stage.
- Counts writeback retirements on the register-file write port.
- Raises stall when an issuing instruction needs a register whose write is still pending.

Parameters:
- NUM_REGS, 32, number of architectural registers; entry 0 is hardwired zero.
- ADDR_W, 5, register address width.
- CNT_W, 2, width of each per-register pending-write counter; maximum 2^CNT_W-1 outstanding writes.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- flush_i  input  1  synchronous clear of all tracking, for pipeline flush.
- issue_valid_i  input  1  decode presents an instruction.
- issue_rs_i  input  ADDR_W  source register A.
- issue_rt_i  input  ADDR_W  source register B.
- issue_use_rs_i  input  1  instruction reads rs.
- issue_use_rt_i  input  1  instruction reads rt.
- issue_rd_i  input  ADDR_W  destination register.
- issue_wr_i  input  1  instruction writes rd.
- issue_ready_o  output  1  instruction accepted this cycle.
- stall_o  output  1  equals issue_valid_i & ~issue_ready_o.
- wb_valid_i  input  1  register-file write performed this cycle (RegWrite).
- wb_rd_i  input  ADDR_W  register written.
- busy_o  output  NUM_REGS  bit i set when counter i != 0; bit 0 always 0.
- outstanding_o  output  ADDR_W+CNT_W  total pending writes, saturating.
- err_o  output  1  sticky underflow or overflow flag.

Behaviour:
- Reset (async, rst_i=1):
  - All counters 0, outstanding_o=0, err_o=0, busy_o=0.
  - issue_ready_o and stall_o are combinational and follow from cleared state.
- Register 0:
  - Never tracked.
  - Issue with rd=0 and writeback to 0 leave counters unchanged.
  - Sources equal to 0 never stall.
- Hazard terms (combinational, zero latency):
  - raw_rs = issue_use_rs_i & rs!=0 & pend(rs).
  - raw_rt = issue_use_rt_i & rt!=0 & pend(rt).
  - waw_full = issue_wr_i & rd!=0 & cnt(rd)==max & ~(wb hit on rd).
- Ready: issue_ready_o = ~flush_i & ~(raw_rs | raw_rt | waw_full).
- Fire: issue_fire = issue_valid_i & issue_ready_o.
- Per-register counter update at the clock edge, r != 0:
  - inc = issue_fire & issue_wr_i & rd==r.
  - dec = wb_valid_i & wb_rd_i==r & cnt(r)!=0.
  - inc & ~dec: counter +1.
  - dec & ~inc: counter -1.
  - inc & dec: counter unchanged.
- Underflow: wb_valid_i to a register whose counter is 0 is ignored, and err_o is set.
- Overflow guard: waw_full prevents overflow. If it is ever violated, err_o is set and the counter saturates.
- outstanding_o:
  - +1 on each inc, -1 on each accepted dec; both in one cycle means no change.
  - Clamped at 0 and at its maximum.
- flush_i:
  - Priority over issue and writeback.
  - Next edge clears all counters and outstanding_o; err_o is kept.
  - issue_ready_o=0 during the flush cycle.
- Reset asserted mid-operation clears immediately regardless of clock. No issue is accepted while rst_i=1.
- Same rs and rt: the hazard is evaluated once. rd equal to rs is legal; it checks the old pending state only.

Optional Feature:
- Macro WB_BYPASS_EN, matching the register file's same-cycle write-through read.
- Defined:
  - pend(x) = cnt(x) - (wb_valid_i & wb_rd_i==x & cnt(x)!=0) != 0.
  - A source whose last pending write retires in the current cycle does not stall.
- Undefined:
  - pend(x) = cnt(x) != 0.
  - The instruction stalls one extra cycle and issues the cycle after writeback.

Decomposition:
- Shared package reg_sched_pkg holds:
  - constants NUM_REGS, ADDR_W, CNT_W;
  - the zero-register index;
  - typedef reg_addr_t (ADDR_W bits);
  - typedef pend_cnt_t (CNT_W bits).
- Sub-module sb_counter: one CNT_W up/down saturating counter with inc, dec, clear, and an underflow pulse.
- The top level generates NUM_REGS-1 instances of sb_counter and holds the hazard logic, the total counter and err_o.

Test Plan:
- Reset, then issue rd=5 wr=1 -> busy_o[5]=1 next cycle, outstanding_o=1.
- Next cycle issue use_rs rs=5 -> stall_o=1.
- wb rd=5 -> with WB_BYPASS_EN, stall_o=0 in the same cycle. Without it, stall_o=0 one cycle later and busy_o[5]=0.
- Issue rd=7 three times with no writeback -> counter 3, fourth issue to rd=7 stalls (waw_full).
- Same cycle wb rd=7 -> fourth issue accepted, counter stays 3, outstanding_o stays 3.
- wb rd=9 with counter 0 -> counters unchanged, err_o=1 and stays 1 until reset; a later flush_i leaves err_o=1.
- Issue rd=0 wr=1, then use_rs rs=0 -> no busy bit, outstanding_o=0, never stalls.
- Load rd=3 and rd=4, then flush_i=1 -> issue_ready_o=0 that cycle, all busy_o=0 next cycle.
- Assert rst_i between clock edges -> outputs cleared immediately.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-file issue scoreboard.
package reg_sched_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int OUT_W    = ADDR_W + CNT_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;
  typedef logic [OUT_W-1:0]  out_cnt_t;

  localparam reg_addr_t ZERO_REG = '0;
  localparam pend_cnt_t CNT_MAX  = '1;
  localparam out_cnt_t  OUT_MAX  = '1;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and status bundle between decode/writeback (master) and the scoreboard (slave).
interface reg_scoreboard_if;
  import reg_sched_pkg::*;

  logic                flush_i;
  logic                issue_valid_i;
  reg_addr_t           issue_rs_i;
  reg_addr_t           issue_rt_i;
  logic                issue_use_rs_i;
  logic                issue_use_rt_i;
  reg_addr_t           issue_rd_i;
  logic                issue_wr_i;
  logic                issue_ready_o;
  logic                stall_o;
  logic                wb_valid_i;
  reg_addr_t           wb_rd_i;
  logic [NUM_REGS-1:0] busy_o;
  out_cnt_t            outstanding_o;
  logic                err_o;

  modport master (
    output flush_i, issue_valid_i, issue_rs_i, issue_rt_i, issue_use_rs_i,
           issue_use_rt_i, issue_rd_i, issue_wr_i, wb_valid_i, wb_rd_i,
    input  issue_ready_o, stall_o, busy_o, outstanding_o, err_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_rs_i, issue_rt_i, issue_use_rs_i,
           issue_use_rt_i, issue_rd_i, issue_wr_i, wb_valid_i, wb_rd_i,
    output issue_ready_o, stall_o, busy_o, outstanding_o, err_o
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down with clear and error pulses.
module sb_counter
  import reg_sched_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clear_i,
  input  logic      inc_i,
  input  logic      dec_i,
  output pend_cnt_t cnt_o,
  output logic      dec_ok_o,
  output logic      underflow_o,
  output logic      overflow_o
);
  pend_cnt_t r_cnt;
  logic      w_zero;
  logic      w_full;

  assign w_zero      = (r_cnt == '0);
  assign w_full      = (r_cnt == CNT_MAX);
  assign dec_ok_o    = dec_i & ~w_zero;
  assign underflow_o = dec_i & w_zero;
  assign overflow_o  = inc_i & ~dec_ok_o & w_full;
  assign cnt_o       = r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (inc_i & ~dec_ok_o & ~w_full) begin
      r_cnt <= r_cnt + pend_cnt_t'(1);
    end else if (dec_ok_o & ~inc_i) begin
      r_cnt <= r_cnt - pend_cnt_t'(1);
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Issue scoreboard: per-register pending-write tracking, RAW/WAW-full issue gating.
// Optional macro WB_BYPASS_EN: a source whose last pending write retires this cycle does not stall.
module reg_scoreboard
  import reg_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  reg_scoreboard_if.slave  sb
);
  pend_cnt_t           w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_pend;
  logic [NUM_REGS-1:0] w_dec_ok;
  logic [NUM_REGS-1:0] w_unf;
  logic [NUM_REGS-1:0] w_ovf;
  logic                w_raw_rs;
  logic                w_raw_rt;
  logic                w_waw_full;
  logic                w_ready;
  logic                w_fire;
  logic                w_inc_any;
  logic                w_dec_any;
  out_cnt_t            r_out;
  logic                r_err;

  // Register 0 is hardwired zero and never tracked.
  assign w_cnt[0]    = '0;
  assign w_busy[0]   = 1'b0;
  assign w_pend[0]   = 1'b0;
  assign w_dec_ok[0] = 1'b0;
  assign w_unf[0]    = 1'b0;
  assign w_ovf[0]    = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    logic w_inc;
    logic w_dec_req;
    assign w_inc     = w_fire & sb.issue_wr_i & (sb.issue_rd_i == reg_addr_t'(g));
    assign w_dec_req = sb.wb_valid_i & (sb.wb_rd_i == reg_addr_t'(g));

    sb_counter u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (sb.flush_i),
      .inc_i       (w_inc),
      .dec_i       (w_dec_req),
      .cnt_o       (w_cnt[g]),
      .dec_ok_o    (w_dec_ok[g]),
      .underflow_o (w_unf[g]),
      .overflow_o  (w_ovf[g])
    );

    assign w_busy[g] = (w_cnt[g] != '0);
`ifdef WB_BYPASS_EN
    assign w_pend[g] = ((w_cnt[g] - pend_cnt_t'(w_dec_ok[g])) != '0);
`else
    assign w_pend[g] = w_busy[g];
`endif
  end

  assign w_raw_rs   = sb.issue_use_rs_i & (sb.issue_rs_i != ZERO_REG) & w_pend[sb.issue_rs_i];
  assign w_raw_rt   = sb.issue_use_rt_i & (sb.issue_rt_i != ZERO_REG) & w_pend[sb.issue_rt_i];
  // A writeback hitting rd frees a slot in the same cycle, so a full counter may still accept.
  assign w_waw_full = sb.issue_wr_i & (sb.issue_rd_i != ZERO_REG) &
                      (w_cnt[sb.issue_rd_i] == CNT_MAX) &
                      ~(sb.wb_valid_i & (sb.wb_rd_i == sb.issue_rd_i));
  assign w_ready    = ~sb.flush_i & ~(w_raw_rs | w_raw_rt | w_waw_full);
  assign w_fire     = sb.issue_valid_i & w_ready;
  assign w_inc_any  = w_fire & sb.issue_wr_i & (sb.issue_rd_i != ZERO_REG);
  assign w_dec_any  = |w_dec_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
    end else if (sb.flush_i) begin
      r_out <= '0;
    end else if (w_inc_any & ~w_dec_any & (r_out != OUT_MAX)) begin
      r_out <= r_out + out_cnt_t'(1);
    end else if (w_dec_any & ~w_inc_any & (r_out != '0)) begin
      r_out <= r_out - out_cnt_t'(1);
    end
  end

  // Sticky error survives flush; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (~sb.flush_i & ((|w_unf) | (|w_ovf))) begin
      r_err <= 1'b1;
    end
  end

  assign sb.issue_ready_o = w_ready;
  assign sb.stall_o       = sb.issue_valid_i & ~w_ready;
  assign sb.busy_o        = w_busy;
  assign sb.outstanding_o = r_out;
  assign sb.err_o         = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic vs a counting model.
module tb_reg_scoreboard;
  import reg_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  reg_scoreboard_if sb();

  reg_scoreboard dut (.clk_i(clk), .rst_i(rst), .sb(sb));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int m_cnt [NUM_REGS];
  bit m_err;
  int m_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear_all();
    for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    m_out = 0;
  endfunction

  function automatic bit m_wb_hits(int x);
    return sb.wb_valid_i && int'(sb.wb_rd_i) == x && x != 0;
  endfunction

  function automatic bit m_pend(int x);
    if (x == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    return (m_cnt[x] - ((m_wb_hits(x) && m_cnt[x] > 0) ? 1 : 0)) > 0;
`else
    return m_cnt[x] > 0;
`endif
  endfunction

  function automatic bit m_ready();
    int rd;
    bit haz;
    rd  = int'(sb.issue_rd_i);
    haz = (sb.issue_use_rs_i && m_pend(int'(sb.issue_rs_i))) ||
          (sb.issue_use_rt_i && m_pend(int'(sb.issue_rt_i))) ||
          (sb.issue_wr_i && rd != 0 && m_cnt[rd] == 3 && !m_wb_hits(rd));
    return !sb.flush_i && !haz;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy();
    logic [NUM_REGS-1:0] b;
    b = '0;
    for (int i = 1; i < NUM_REGS; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  function automatic void m_edge();
    int inc_r, dec_r;
    if (sb.flush_i) begin
      m_clear_all();
      return;
    end
    inc_r = -1;
    dec_r = -1;
    if (sb.issue_valid_i && m_ready() && sb.issue_wr_i && sb.issue_rd_i != 0) inc_r = int'(sb.issue_rd_i);
    if (sb.wb_valid_i && sb.wb_rd_i != 0) begin
      if (m_cnt[sb.wb_rd_i] > 0) dec_r = int'(sb.wb_rd_i);
      else m_err = 1'b1;
    end
    if (inc_r >= 0) begin m_cnt[inc_r]++; m_out++; end
    if (dec_r >= 0) begin m_cnt[dec_r]--; m_out--; end
    for (int i = 1; i < NUM_REGS; i++)
      if (m_cnt[i] > 3) begin m_cnt[i] = 3; m_err = 1'b1; end
    if (m_out < 0) m_out = 0;
    if (m_out > 127) m_out = 127;
  endfunction

  // One clock: combinational checks before the edge, state checks just after it.
  task automatic cyc(input string tag);
    bit rdy;
    #1;
    rdy = m_ready();
    check({tag, ".ready"}, sb.issue_ready_o, rdy);
    check({tag, ".stall"}, sb.stall_o, sb.issue_valid_i & ~rdy);
    @(posedge clk);
    m_edge();
    #1;
    check({tag, ".busy"}, sb.busy_o, m_busy());
    check({tag, ".outst"}, sb.outstanding_o, m_out);
    check({tag, ".err"}, sb.err_o, m_err);
  endtask

  task automatic set_issue(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                           input int rd, input bit wr);
    sb.issue_valid_i  = v;
    sb.issue_rs_i     = reg_addr_t'(rs);
    sb.issue_use_rs_i = urs;
    sb.issue_rt_i     = reg_addr_t'(rt);
    sb.issue_use_rt_i = urt;
    sb.issue_rd_i     = reg_addr_t'(rd);
    sb.issue_wr_i     = wr;
  endtask

  task automatic set_wb(input bit v, input int rd);
    sb.wb_valid_i = v;
    sb.wb_rd_i    = reg_addr_t'(rd);
  endtask

  task automatic idle();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    sb.flush_i = 1'b0;
  endtask

  initial begin
    idle();
    m_clear_all();
    m_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.busy", sb.busy_o, 0);
    check("rst.outst", sb.outstanding_o, 0);
    check("rst.err", sb.err_o, 0);
    check("rst.ready", sb.issue_ready_o, 1);
    rst = 1'b0;

    // RAW on rd=5
    set_issue(1, 0, 0, 0, 0, 5, 1);
    cyc("iss5");
    check("iss5.busy5", sb.busy_o[5], 1);
    check("iss5.out1", sb.outstanding_o, 1);
    set_issue(1, 5, 1, 0, 0, 0, 0);
    #1 check("raw5.stall", sb.stall_o, 1);
    cyc("raw5");
    set_wb(1, 5);
`ifdef WB_BYPASS_EN
    #1 check("byp5.stall", sb.stall_o, 0);
    cyc("byp5");
`else
    #1 check("nobyp5.stall", sb.stall_o, 1);
    cyc("nobyp5");
    check("nobyp5.busy5", sb.busy_o[5], 0);
    set_wb(0, 0);
    #1 check("after5.stall", sb.stall_o, 0);
    cyc("after5");
`endif
    idle();

    // WAW-full on rd=7
    set_issue(1, 0, 0, 0, 0, 7, 1);
    for (int i = 0; i < 3; i++) cyc("fill7");
    check("fill7.out3", sb.outstanding_o, 3);
    #1 check("full7.stall", sb.stall_o, 1);
    cyc("full7");
    set_wb(1, 7);
    #1 check("full7wb.stall", sb.stall_o, 0);
    cyc("full7wb");
    check("full7wb.out3", sb.outstanding_o, 3);
    set_wb(0, 0);
    #1 check("still7.stall", sb.stall_o, 1);
    cyc("still7");
    idle();
    set_wb(1, 7);
    for (int i = 0; i < 3; i++) cyc("drain7");
    check("drain7.out0", sb.outstanding_o, 0);

    // Underflow on rd=9
    set_wb(1, 9);
    cyc("unf9");
    check("unf9.err", sb.err_o, 1);
    check("unf9.busy", sb.busy_o, 0);
    idle();

    // Register 0
    set_issue(1, 0, 0, 0, 0, 0, 1);
    cyc("rd0");
    check("rd0.busy", sb.busy_o, 0);
    check("rd0.out", sb.outstanding_o, 0);
    set_issue(1, 0, 1, 0, 1, 0, 0);
    #1 check("rs0.stall", sb.stall_o, 0);
    cyc("rs0");

    // Flush
    set_issue(1, 0, 0, 0, 0, 3, 1);
    cyc("ld3");
    set_issue(1, 0, 0, 0, 0, 4, 1);
    cyc("ld4");
    check("ld4.out2", sb.outstanding_o, 2);
    set_issue(1, 0, 0, 0, 0, 6, 1);
    sb.flush_i = 1'b1;
    #1 check("flush.ready", sb.issue_ready_o, 0);
    cyc("flush");
    check("flush.busy", sb.busy_o, 0);
    check("flush.out", sb.outstanding_o, 0);
    check("flush.err", sb.err_o, 1);
    idle();

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1));
      set_wb($urandom_range(0, 1), $urandom_range(0, 7));
      sb.flush_i = ($urandom_range(0, 19) == 0);
      cyc("rnd");
    end
    idle();

    // Asynchronous reset between edges
    set_issue(1, 0, 0, 0, 0, 2, 1);
    cyc("pre_rst");
    #3 rst = 1'b1;
    #1;
    check("arst.busy", sb.busy_o, 0);
    check("arst.outst", sb.outstanding_o, 0);
    check("arst.err", sb.err_o, 0);
    m_clear_all();
    m_err = 1'b0;
    set_issue(1, 0, 0, 0, 0, 8, 1);
    @(posedge clk);
    #1;
    check("arst_hold.busy", sb.busy_o, 0);
    check("arst_hold.outst", sb.outstanding_o, 0);
    rst = 1'b0;
    cyc("post_rst");
    check("post_rst.busy8", sb.busy_o[8], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
